// File: rtl/register_file_8x16.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one write port; optional hardwired r0 and write-through bypass.
// Latency: reads 0 cycles, writes visible after 1 rising edge; no backpressure, every write is accepted.
module register_file_8x16 #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_regWrite,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_wr_to_zero;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_dat  [2];

    assign w_wr_to_zero = ZERO_REG && (wr_addr == '0);
    // Qualifying with rst_n keeps bypass quiet while reset is held.
    assign w_wr_en      = rst_n && sig_regWrite && !w_wr_to_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign w_rd_addr[0] = rd_addr1;
    assign w_rd_addr[1] = rd_addr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        always_comb begin
            w_rd_dat[p] = r_regs[w_rd_addr[p]];
            if (ZERO_REG && (w_rd_addr[p] == '0)) begin
                w_rd_dat[p] = '0;
            end
            if (BYPASS && w_wr_en && (w_rd_addr[p] == wr_addr)) begin
                w_rd_dat[p] = wr_data;
            end
            if (!rst_n) begin
                w_rd_dat[p] = '0;
            end
        end
    end

    assign data1 = w_rd_dat[0];
    assign data2 = w_rd_dat[1];

endmodule

// File: tb/tb_register_file_8x16.sv
// Directed bench for register_file_8x16: one write-through instance and one without bypass share all stimulus.
// Stimulus queues expected read data; a monitor pops and compares on each sample strobe.
module tb_register_file_8x16;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        sig_regWrite;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic [15:0] bp_data1, bp_data2;
    logic [15:0] nb_data1, nb_data2;

    typedef struct {
        string       name;
        logic [15:0] bp1;
        logic [15:0] bp2;
        logic [15:0] nb1;
        logic [15:0] nb2;
    } exp_t;

    exp_t exp_q[$];
    logic sample_vld;
    int   checks;
    int   failures;

    register_file_8x16 #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_bp (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_regWrite (sig_regWrite),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .data1        (bp_data1),
        .data2        (bp_data2)
    );

    register_file_8x16 #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_regWrite (sig_regWrite),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .data1        (nb_data1),
        .data2        (nb_data2)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per strobe and compares all four read ports.
    always @(posedge sample_vld) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL monitor_underflow: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            cmp({e.name, ".bp.data1"}, bp_data1, e.bp1);
            cmp({e.name, ".bp.data2"}, bp_data2, e.bp2);
            cmp({e.name, ".nb.data1"}, nb_data1, e.nb1);
            cmp({e.name, ".nb.data2"}, nb_data2, e.nb2);
        end
    end

    task automatic rd_check(input string nm, input logic [2:0] a1, input logic [2:0] a2,
                            input logic [15:0] bp1, input logic [15:0] bp2,
                            input logic [15:0] nb1, input logic [15:0] nb2);
        exp_t e;
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
        e.name = nm; e.bp1 = bp1; e.bp2 = bp2; e.nb1 = nb1; e.nb2 = nb2;
        exp_q.push_back(e);
        sample_vld = 1'b1;
        #1;
        sample_vld = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        sig_regWrite = 1'b1;
        wr_addr      = a;
        wr_data      = d;
        @(posedge clk);
        #1;
        sig_regWrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] p1 [4];
        logic [2:0] p2 [4];
        checks = 0; failures = 0;
        sample_vld = 1'b0; clk_en = 1'b0;
        rst_n = 1'b1; sig_regWrite = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;

        // 1. Asynchronous reset with the clock stopped.
        #2 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_check("reset_sweep", 3'(i), 3'(7 - i), 16'h0, 16'h0, 16'h0, 16'h0);
        end
        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 2. Write enable low: nothing may change.
        p1[0] = 3'd1; p2[0] = 3'd2; p1[1] = 3'd2; p2[1] = 3'd1;
        p1[2] = 3'd1; p2[2] = 3'd3; p1[3] = 3'd3; p2[3] = 3'd2;
        sig_regWrite = 1'b0; wr_addr = 3'd0; wr_data = 16'd69;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_check("write_disabled", p1[i], p2[i], 16'h0, 16'h0, 16'h0, 16'h0);
        end

        // 3. Basic writes and dual-port reads.
        write_reg(3'd1, 16'h1234);
        write_reg(3'd2, 16'hABCD);
        write_reg(3'd3, 16'h0069);
        @(negedge clk);
        rd_check("read_1_2", 3'd1, 3'd2, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD);
        rd_check("read_3_3", 3'd3, 3'd3, 16'h0069, 16'h0069, 16'h0069, 16'h0069);

        // 4. Register 0 ignores writes, even on the bypass path.
        @(negedge clk);
        sig_regWrite = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rd_check("r0_before_edge", 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        sig_regWrite = 1'b0;
        rd_check("r0_after_edge", 3'd0, 3'd1, 16'h0, 16'h1234, 16'h0, 16'h1234);

        // 5. Bypass versus registered read of a register being written.
        write_reg(3'd5, 16'h0011);
        @(negedge clk);
        sig_regWrite = 1'b1; wr_addr = 3'd5; wr_data = 16'h0022;
        rd_check("bypass_before_edge", 3'd1, 3'd5, 16'h1234, 16'h0022, 16'h1234, 16'h0011);
        @(posedge clk);
        #1;
        rd_check("bypass_after_edge", 3'd5, 3'd5, 16'h0022, 16'h0022, 16'h0022, 16'h0022);
        sig_regWrite = 1'b0;

        // 6. Reset in the middle of traffic.
        for (int i = 1; i < 8; i++) begin
            write_reg(3'(i), 16'(i * 16'h1111));
        end
        @(negedge clk);
        rd_check("filled_7_4", 3'd7, 3'd4, 16'h7777, 16'h4444, 16'h7777, 16'h4444);
        @(negedge clk);
        sig_regWrite = 1'b1; wr_addr = 3'd6; wr_data = 16'hABCD;
        rd_check("pending_write", 3'd6, 3'd2, 16'hABCD, 16'h2222, 16'h6666, 16'h2222);
        rst_n = 1'b0;
        rd_check("midreset_6_2", 3'd6, 3'd2, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_check("midreset_sweep", 3'(2 * i + 1), 3'(2 * i), 16'h0, 16'h0, 16'h0, 16'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("release_before_edge", 3'd6, 3'd3, 16'hABCD, 16'h0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        sig_regWrite = 1'b0;
        rd_check("release_after_edge", 3'd6, 3'd1, 16'hABCD, 16'h0, 16'hABCD, 16'h0);

        #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_8x16.md
Name: register_file_8x16

Overview:
General-purpose register file for the 16-bit MIPS-style datapath.
- 8 registers of 16 bits each.
- Two asynchronous (combinational) read ports feed ALU operands A and B.
- One synchronous write port is driven by writeback.
- Register 0 is hardwired to zero, per MIPS convention.

Parameters:
DATA_W, 16, register and data width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W = 8 registers
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register
BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data (write-through); 0 = returns the stored (old) value

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
sig_regWrite  input  1  write enable
wr_addr  input  ADDR_W  write register index
wr_data  input  DATA_W  write data
rd_addr1  input  ADDR_W  read port 1 register index
rd_addr2  input  ADDR_W  read port 2 register index
data1  output  DATA_W  read port 1 data (combinational)
data2  output  DATA_W  read port 2 data (combinational)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Storage: 2**ADDR_W registers of DATA_W bits.
- Reset:
  - rst_n=0 immediately clears every register to 0, with no clock needed.
  - Reset is held while low; writes are ignored during reset.
  - Release is synchronised by the system; the first write takes effect on the first rising clk edge with rst_n=1.
- Reset mid-operation: a reset asserted between edges discards any pending write. All registers read 0 combinationally from the moment rst_n falls.
- Write:
  - On rising clk edge with rst_n=1 and sig_regWrite=1: reg[wr_addr] <= wr_data.
  - Latency 1 cycle: new value is visible in the stored array after the edge.
  - sig_regWrite=0: no register changes, regardless of wr_addr/wr_data.
- Register 0 (ZERO_REG=1): writes to address 0 are discarded; reads of address 0 return 0 always.
- Read:
  - data1 = reg[rd_addr1] and data2 = reg[rd_addr2], purely combinational, zero-cycle latency.
  - Outputs change in the same delta as an address change.
  - Both ports are independent; reading the same address on both ports is legal and returns identical data.
- Bypass (BYPASS=1):
  - If sig_regWrite=1, rst_n=1, rd_addrN == wr_addr, and (ZERO_REG=0 or wr_addr!=0), then dataN = wr_data combinationally, before the edge.
  - Applies independently to each port.
  - During reset, bypass is disabled and outputs read 0.
- BYPASS=0: the read returns the old value until the edge, and the new value after it.
- During reset, data1/data2 = 0 for all addresses.
- No X-propagation:
  - Registers are never uninitialised after the first reset.
  - All address values are legal and in range, with no wrap logic needed.
- Width: wr_data is stored verbatim; no sign extension or truncation inside the block.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle with no clock edge; sweep rd_addr1/rd_addr2 over 0..7 -> data1=data2=16'd0 at every address.
2. Write disabled: after reset, set sig_regWrite=0, wr_addr=0, wr_data=16'd69; clock 4 cycles while reading the pairs (1,2), (2,1), (1,3), (3,2) -> all reads return 0.
3. Write/read: write 16'h1234 to r1, 16'hABCD to r2, 16'h0069 to r3 on successive edges.
   - Read (1,2) -> data1=16'h1234, data2=16'hABCD.
   - Read (3,3) -> both 16'h0069.
4. Register 0: sig_regWrite=1, wr_addr=0, wr_data=16'hFFFF; clock -> rd_addr1=0 gives data1=0, before and after the edge.
5. Bypass: r5 holds 16'h0011; with sig_regWrite=1, wr_addr=5, wr_data=16'h0022, rd_addr2=5.
   - BYPASS=1: data2=16'h0022 before the edge.
   - BYPASS=0: data2=16'h0011 before the edge, 16'h0022 after.
6. Async reset mid-operation: fill r1..r7 with 16'h1111..16'h7777, then pull rst_n low between edges while sig_regWrite=1 -> all reads 0 immediately; after release, the write takes effect only on the next edge.
